// File: rtl/fpmul.sv
// IEEE-754 binary32 multiplier with one registered output stage and IEEE exception flags.
// Define DENORM_EN for full gradual underflow; otherwise subnormal inputs and results flush to zero.
module fpmul #(
   parameter int WIDTH    = 32,
   parameter int WCONTROL = 2,
   parameter int WFLAG    = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [WIDTH-1:0]    A,
   input  logic [WIDTH-1:0]    B,
   input  logic [WCONTROL-1:0] control,
   output logic [WIDTH-1:0]    Out,
   output logic [WFLAG-1:0]    flags
);

   localparam logic [31:0] QNAN = 32'h7FC0_0000;
   localparam logic [1:0]  RNE  = 2'b00;
   localparam logic [1:0]  RZ   = 2'b01;
   localparam logic [1:0]  RP   = 2'b10;
   localparam logic [1:0]  RM   = 2'b11;

   logic        sa, sb, sr;
   logic [7:0]  ea, eb;
   logic [22:0] fa, fb;
   logic        a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
   logic [23:0] ma, mb;
   logic signed [10:0] xa, xb, e_n;
   logic [47:0] prod, mn, ms;
   logic        tiny, g, rb, st, inx, inc, ovf, away;
   logic [7:0]  e_m1;
   logic [30:0] rnd;
   logic [31:0] res;
   logic [4:0]  flg;

   assign sa = A[31];
   assign sb = B[31];
   assign ea = A[30:23];
   assign eb = B[30:23];
   assign fa = A[22:0];
   assign fb = B[22:0];
   assign sr = sa ^ sb;

   assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
   assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
   assign a_snan = a_nan && !fa[22];
   assign b_snan = b_nan && !fb[22];
   assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
   assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);

`ifdef DENORM_EN
   // Left shift that brings the leading one of a subnormal fraction up to bit 23.
   function automatic logic [4:0] lead_shift(input logic [22:0] f);
      logic [4:0] s;
      s = 5'd0;
      for (int i = 0; i <= 22; i++)
         if (f[i]) s = 5'(23 - i);
      return s;
   endfunction

   logic        a_sub, b_sub, lost;
   logic [4:0]  sh_a, sh_b;
   logic signed [10:0] shn;
   logic [5:0]  sh;

   assign a_zero = (ea == 8'd0) && (fa == 23'd0);
   assign b_zero = (eb == 8'd0) && (fb == 23'd0);
   assign a_sub  = (ea == 8'd0) && (fa != 23'd0);
   assign b_sub  = (eb == 8'd0) && (fb != 23'd0);
   assign sh_a   = lead_shift(fa);
   assign sh_b   = lead_shift(fb);
   assign ma = a_sub ? ({1'b0, fa} << sh_a) : {1'b1, fa};
   assign mb = b_sub ? ({1'b0, fb} << sh_b) : {1'b1, fb};
   assign xa = a_sub ? (11'sd1 - $signed({6'b0, sh_a})) : $signed({3'b0, ea});
   assign xb = b_sub ? (11'sd1 - $signed({6'b0, sh_b})) : $signed({3'b0, eb});
`else
   assign a_zero = (ea == 8'd0);
   assign b_zero = (eb == 8'd0);
   assign ma = {1'b1, fa};
   assign mb = {1'b1, fb};
   assign xa = $signed({3'b0, ea});
   assign xb = $signed({3'b0, eb});
`endif

   assign prod = ma * mb;
   assign mn   = prod[47] ? prod : {prod[46:0], 1'b0};
   assign e_n  = xa + xb - 11'sd127 + $signed({10'b0, prod[47]});
   assign tiny = (e_n < 11'sd1);

`ifdef DENORM_EN
   // Tiny results shift right into the subnormal range; shifted-out bits feed sticky.
   assign shn  = 11'sd1 - e_n;
   assign sh   = !tiny ? 6'd0 : (shn > 11'sd48) ? 6'd48 : shn[5:0];
   assign ms   = mn >> sh;
   assign lost = |(mn & ~({48{1'b1}} << sh));
`else
   assign ms   = mn;
`endif

   assign g  = ms[23];
   assign rb = ms[22];
`ifdef DENORM_EN
   assign st = (|ms[21:0]) | lost;
`else
   assign st = |ms[21:0];
`endif
   assign inx = g | rb | st;

   always_comb begin
      inc = 1'b0;
      case (control)
         RNE: inc = g & (rb | st | ms[24]);
         RZ:  inc = 1'b0;
         RP:  inc = !sr & inx;
         RM:  inc = sr & inx;
         default: inc = 1'b0;
      endcase
   end

   // The hidden bit ms[47] adds back the one subtracted from the exponent, so a
   // rounding carry ripples naturally into the exponent (and subnormal -> normal).
   assign e_m1 = tiny ? 8'd0 : (e_n[7:0] - 8'd1);
   assign rnd  = {e_m1, 23'd0} + {7'd0, ms[47:24]} + {30'd0, inc};
   assign ovf  = !tiny && ((e_n > 11'sd254) || (rnd[30:23] == 8'hFF));
   assign away = (control == RNE) || (control == RP && !sr) || (control == RM && sr);

   always_comb begin
      res = 32'd0;
      flg = 5'd0;
      if (a_nan || b_nan) begin
         res    = QNAN;
         flg[4] = a_snan | b_snan;
      end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
         res    = QNAN;
         flg[4] = 1'b1;
      end else if (a_inf || b_inf) begin
         res = {sr, 8'hFF, 23'd0};
      end else if (a_zero || b_zero) begin
         res = {sr, 31'd0};
      end else if (ovf) begin
         res    = away ? {sr, 8'hFF, 23'd0} : {sr, 31'h7F7F_FFFF};
         flg[2] = 1'b1;
         flg[0] = 1'b1;
      end else begin
`ifdef DENORM_EN
         res    = {sr, rnd};
         flg[1] = tiny & inx;
         flg[0] = inx;
`else
         if (tiny) begin
            res    = {sr, 31'd0};
            flg[1] = 1'b1;
            flg[0] = 1'b1;
         end else begin
            res    = {sr, rnd};
            flg[0] = inx;
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Out   <= '0;
         flags <= '0;
      end else begin
         Out   <= res;
         flags <= flg;
      end
   end

endmodule

// File: tb/tb_fpmul.sv
// Directed self-checking bench for fpmul: specials, rounding modes, overflow, underflow and reset.
module tb_fpmul;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] A, B;
   logic [1:0]  control;
   logic [31:0] Out;
   logic [4:0]  flags;

   int tests = 0;
   int fails = 0;

   fpmul dut (
      .clk     (clk),
      .reset   (reset),
      .A       (A),
      .B       (B),
      .control (control),
      .Out     (Out),
      .flags   (flags)
   );

   always #5 clk = ~clk;

   task automatic check_now(input string tag, input logic [31:0] eo, input logic [4:0] ef);
      tests++;
      assert (Out === eo) else begin
         fails++;
         $error("FAIL %s out: got %h expected %h", tag, Out, eo);
      end
      tests++;
      assert (flags === ef) else begin
         fails++;
         $error("FAIL %s flags: got %h expected %h", tag, flags, ef);
      end
   endtask

   task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] ctl, input logic [31:0] eo, input logic [4:0] ef);
      A = a;
      B = b;
      control = ctl;
      @(posedge clk);
      #1;
      check_now(tag, eo, ef);
   endtask

   initial begin
      reset = 1'b1;
      A = 32'h4000_0000;
      B = 32'h4040_0000;
      control = 2'b00;
      #2;
      check_now("reset_state", 32'h0, 5'h00);
      @(posedge clk);
      #1;
      check_now("reset_held", 32'h0, 5'h00);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_now("after_release", 32'h0, 5'h00);

      step("basic",      32'h4000_0000, 32'h4040_0000, 2'b00, 32'h40C0_0000, 5'h00);
      step("neg",        32'hC000_0000, 32'h4040_0000, 2'b00, 32'hC0C0_0000, 5'h00);
      step("negzero",    32'h8000_0000, 32'h3F80_0000, 2'b00, 32'h8000_0000, 5'h00);
      step("rnd_rne",    32'h3F80_0001, 32'h3F80_0001, 2'b00, 32'h3F80_0002, 5'h01);
      step("rnd_rz",     32'h3F80_0001, 32'h3F80_0001, 2'b01, 32'h3F80_0002, 5'h01);
      step("rnd_rp",     32'h3F80_0001, 32'h3F80_0001, 2'b10, 32'h3F80_0003, 5'h01);
      step("rnd_rm",     32'h3F80_0001, 32'h3F80_0001, 2'b11, 32'h3F80_0002, 5'h01);
      step("rnd_neg_rm", 32'hBF80_0001, 32'h3F80_0001, 2'b11, 32'hBF80_0003, 5'h01);
      step("rnd_neg_rp", 32'hBF80_0001, 32'h3F80_0001, 2'b10, 32'hBF80_0002, 5'h01);
      step("ovf_rne",    32'h7F7F_FFFF, 32'h4000_0000, 2'b00, 32'h7F80_0000, 5'h05);
      step("ovf_rz",     32'h7F7F_FFFF, 32'h4000_0000, 2'b01, 32'h7F7F_FFFF, 5'h05);
      step("ovf_neg_rm", 32'hFF7F_FFFF, 32'h4000_0000, 2'b11, 32'hFF80_0000, 5'h05);
      step("ovf_neg_rp", 32'hFF7F_FFFF, 32'h4000_0000, 2'b10, 32'hFF7F_FFFF, 5'h05);
      step("inf_x_zero", 32'h7F80_0000, 32'h0000_0000, 2'b00, 32'h7FC0_0000, 5'h10);
      step("zero_x_inf", 32'h8000_0000, 32'h7F80_0000, 2'b00, 32'h7FC0_0000, 5'h10);
      step("snan",       32'h7F80_0001, 32'h3F80_0000, 2'b00, 32'h7FC0_0000, 5'h10);
      step("qnan",       32'h3F80_0000, 32'hFFC0_0000, 2'b00, 32'h7FC0_0000, 5'h00);
      step("inf_x_fin",  32'hFF80_0000, 32'h4000_0000, 2'b00, 32'hFF80_0000, 5'h00);
`ifdef DENORM_EN
      step("underflow",  32'h0080_0000, 32'h3F00_0000, 2'b00, 32'h0040_0000, 5'h00);
`else
      step("underflow",  32'h0080_0000, 32'h3F00_0000, 2'b00, 32'h0000_0000, 5'h03);
`endif

      step("pre_reset",  32'h4000_0000, 32'h4040_0000, 2'b00, 32'h40C0_0000, 5'h00);
      A = 32'h7F7F_FFFF;
      B = 32'h4000_0000;
      #2;
      reset = 1'b1;
      #1;
      check_now("mid_reset", 32'h0, 5'h00);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_now("mid_release", 32'h0, 5'h00);
      step("post_reset", 32'h7F7F_FFFF, 32'h4000_0000, 2'b00, 32'h7F80_0000, 5'h05);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
